// File: rtl/tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
//   Parametrised free-running counter with an internal clock-enable prescaler.
//   The prescaler divides clk down to TICK_HZ.
//   On every prescaler rollover the count moves according to mode:
//     00 hold, 01 up, 10 down, 11 bounce (ping-pong).
//   A one-cycle tc pulse marks the terminal count.
//   A synchronous load overrides everything except the asynchronous reset.
//
//   Optional feature macro: COUNTER_SATURATE_EN
//     When defined, up mode sticks at MAX and down mode sticks at 0.
//     tc pulses on every tick spent at that bound.
//     When undefined, both modes wrap around.
// -----------------------------------------------------------------------------
module tick_counter #(
    parameter int WIDTH      = 4,
    parameter int CLOCK_FREQ = 125000000,
    parameter int TICK_HZ    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             dir_down
);

    // Prescaler geometry.
    // A ratio below one is clamped so that the divider still ticks every cycle.
    localparam int CYCLES_RAW      = CLOCK_FREQ / TICK_HZ;
    localparam int CYCLES_PER_TICK = (CYCLES_RAW >= 1) ? CYCLES_RAW : 1;
    localparam int PRESC_W         = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_TICK - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(32'd1);

    // Count bounds.
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    // Registered state; the outputs are driven straight from these.
    logic [PRESC_W-1:0] prescaler_r;
    logic [WIDTH-1:0]   count_r;
    logic               tick_r;
    logic               tc_r;
    logic               dir_down_r;

    // Combinational next-state terms.
    mode_e              mode_s;
    logic               presc_wrap_s;
    logic [WIDTH-1:0]   next_count_s;
    logic               next_dir_s;
    logic               next_tc_s;

    assign mode_s = mode_e'(mode);

    // Detect the prescaler cycle on which a tick is due.
    always_comb begin
        presc_wrap_s = 1'b0;
        if (prescaler_r == PRESC_LAST) begin
            presc_wrap_s = 1'b1;
        end else begin
            presc_wrap_s = 1'b0;
        end
    end

    // Compute the count, direction and terminal-count value for the next tick.
    always_comb begin
        next_count_s = count_r;
        next_dir_s   = dir_down_r;
        next_tc_s    = 1'b0;
        case (mode_s)
            MODE_HOLD: begin
                next_count_s = count_r;
                next_tc_s    = 1'b0;
            end
            MODE_UP: begin
                if (count_r == CNT_MAX) begin
`ifdef COUNTER_SATURATE_EN
                    next_count_s = CNT_MAX;
`else
                    next_count_s = CNT_ZERO;
`endif
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = count_r + CNT_ONE;
                    next_tc_s    = 1'b0;
                end
            end
            MODE_DOWN: begin
                if (count_r == CNT_ZERO) begin
`ifdef COUNTER_SATURATE_EN
                    next_count_s = CNT_ZERO;
`else
                    next_count_s = CNT_MAX;
`endif
                    next_tc_s    = 1'b1;
                end else begin
                    next_count_s = count_r - CNT_ONE;
                    next_tc_s    = 1'b0;
                end
            end
            MODE_BOUNCE: begin
                if (!dir_down_r) begin
                    // Rising leg: turn around at the top without dwelling on MAX.
                    if (count_r == CNT_MAX) begin
                        next_count_s = CNT_MAX - CNT_ONE;
                        next_dir_s   = 1'b1;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = count_r + CNT_ONE;
                        next_dir_s   = 1'b0;
                        next_tc_s    = 1'b0;
                    end
                end else begin
                    // Falling leg: turn around at the bottom without dwelling on zero.
                    if (count_r == CNT_ZERO) begin
                        next_count_s = CNT_ONE;
                        next_dir_s   = 1'b0;
                        next_tc_s    = 1'b1;
                    end else begin
                        next_count_s = count_r - CNT_ONE;
                        next_dir_s   = 1'b1;
                        next_tc_s    = 1'b0;
                    end
                end
            end
            default: begin
                next_count_s = count_r;
                next_dir_s   = dir_down_r;
                next_tc_s    = 1'b0;
            end
        endcase
    end

    // Prescaler, count and pulse registers.
    // Load beats ce.
    // The count moves only on the edge that wraps the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r <= PRESC_ZERO;
            count_r     <= CNT_ZERO;
            tick_r      <= 1'b0;
            tc_r        <= 1'b0;
            dir_down_r  <= 1'b0;
        end else if (load) begin
            prescaler_r <= PRESC_ZERO;
            count_r     <= load_value;
            tick_r      <= 1'b0;
            tc_r        <= 1'b0;
            dir_down_r  <= 1'b0;
        end else if (ce) begin
            if (presc_wrap_s) begin
                prescaler_r <= PRESC_ZERO;
                count_r     <= next_count_s;
                tick_r      <= 1'b1;
                tc_r        <= next_tc_s;
                dir_down_r  <= next_dir_s;
            end else begin
                prescaler_r <= prescaler_r + PRESC_ONE;
                count_r     <= count_r;
                tick_r      <= 1'b0;
                tc_r        <= 1'b0;
                dir_down_r  <= dir_down_r;
            end
        end else begin
            // Frozen: keep phase, count and direction; suppress the pulses.
            prescaler_r <= prescaler_r;
            count_r     <= count_r;
            tick_r      <= 1'b0;
            tc_r        <= 1'b0;
            dir_down_r  <= dir_down_r;
        end
    end

    assign count    = count_r;
    assign tick     = tick_r;
    assign tc       = tc_r;
    assign dir_down = dir_down_r;

endmodule

// File: tb/tb_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_tick_counter
//   Directed bench for tick_counter.
//   Configuration: WIDTH=4, CLOCK_FREQ=8, TICK_HZ=2, which gives 4 cycles per tick.
//   An integer reference model is compared against the DUT on every cycle.
//   Literal expectations at key points pin that model down.
// -----------------------------------------------------------------------------
module tb_tick_counter;

    localparam int WIDTH = 4;
    localparam int CPT   = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ce;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;
    logic             dir_down;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    tick_counter #(
        .WIDTH      (WIDTH),
        .CLOCK_FREQ (8),
        .TICK_HZ    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tick       (tick),
        .tc         (tc),
        .dir_down   (dir_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct packed {
        int count;
        int phase;
        bit dir;
        bit tick;
        bit tc;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t s, bit ld, int lv, bit en, int md);
        model_t n = s;
        n.tick = 1'b0;
        n.tc   = 1'b0;
        if (ld) begin
            n.count = lv;
            n.phase = 0;
            n.dir   = 1'b0;
        end else if (en) begin
            n.phase = (s.phase + 1) % CPT;
            if (n.phase == 0) begin
                n.tick = 1'b1;
                case (md)
                    1: begin
`ifdef COUNTER_SATURATE_EN
                        n.tc    = (s.count == MAXV);
                        n.count = (s.count == MAXV) ? MAXV : s.count + 1;
`else
                        n.count = (s.count + 1) % (MAXV + 1);
                        n.tc    = (n.count == 0);
`endif
                    end
                    2: begin
`ifdef COUNTER_SATURATE_EN
                        n.tc    = (s.count == 0);
                        n.count = (s.count == 0) ? 0 : s.count - 1;
`else
                        n.count = (s.count + MAXV) % (MAXV + 1);
                        n.tc    = (n.count == MAXV);
`endif
                    end
                    3: begin
                        // Reflect off the ends: a step that would leave the range goes back.
                        int step = s.dir ? -1 : 1;
                        int tgt  = s.count + step;
                        if (tgt < 0 || tgt > MAXV) begin
                            n.dir   = ~s.dir;
                            n.count = s.count - step;
                            n.tc    = 1'b1;
                        end else begin
                            n.count = tgt;
                        end
                    end
                    default: n.count = s.count;
                endcase
            end
        end
        return n;
    endfunction

    // Advance the reference model on each edge; an async reset clears it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, load, int'(load_value), ce, int'(mode));
    end

    // Compare the DUT against the model shortly after every rising edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("model_count", int'(count), m.count);
            check("model_tick",  int'(tick), int'(m.tick));
            check("model_tc",    int'(tc), int'(m.tc));
            check("model_dir",   int'(dir_down), int'(m.dir));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; mode = 2'b00; load = 1'b0; load_value = '0;
        cyc(3);
        // Reset state.
        check("rst_count", int'(count), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_dir", int'(dir_down), 0);

        // 1: up count; tick every 4th cycle and a full wrap after 16 ticks.
        rst_n = 1'b1; ce = 1'b1; mode = 2'b01; chk_en = 1'b1;
        cyc(3);
        check("up_no_tick_yet", int'(tick), 0);
        cyc(1);
        check("up_first_count", int'(count), 1);
        check("up_first_tick", int'(tick), 1);
        cyc(60);
        check("up_wrap_count", int'(count), 0);
        check("up_wrap_tc", int'(tc), 1);

        // 2: down from 0 wraps to 15 with tc, then 14, 13.
        mode = 2'b10;
        cyc(4);
        check("down_wrap_count", int'(count), 15);
        check("down_wrap_tc", int'(tc), 1);
        cyc(8);
        check("down_count13", int'(count), 13);
        check("down_tc_low", int'(tc), 0);

        // 3: bounce from 13 through 15 back down to 0 and up again.
        mode = 2'b11;
        cyc(12);
        check("bounce_top_count", int'(count), 14);
        check("bounce_top_dir", int'(dir_down), 1);
        check("bounce_top_tc", int'(tc), 1);
        cyc(60);
        check("bounce_bot_count", int'(count), 1);
        check("bounce_bot_dir", int'(dir_down), 0);
        check("bounce_bot_tc", int'(tc), 1);

        // 4: freeze mid-period for 10 cycles; resume at the exact phase.
        cyc(2);
        ce = 1'b0;
        cyc(10);
        check("freeze_count", int'(count), 1);
        check("freeze_tick", int'(tick), 0);
        ce = 1'b1;
        cyc(1);
        check("resume_no_tick", int'(tick), 0);
        cyc(1);
        check("resume_tick", int'(tick), 1);
        check("resume_count", int'(count), 2);

        // Hold mode keeps ticking without moving the count.
        mode = 2'b00;
        cyc(8);
        check("hold_count", int'(count), 2);
        check("hold_tc", int'(tc), 0);

        // 5: load while frozen with bounce direction down.
        mode = 2'b11;
        cyc(56);
        check("pre_load_count", int'(count), 14);
        check("pre_load_dir", int'(dir_down), 1);
        ce = 1'b0; load = 1'b1; load_value = 4'd9;
        cyc(1);
        load = 1'b0;
        check("load_count", int'(count), 9);
        check("load_dir", int'(dir_down), 0);
        check("load_tick", int'(tick), 0);
        cyc(3);
        ce = 1'b1;
        cyc(3);
        check("post_load_no_tick", int'(tick), 0);
        cyc(1);
        check("post_load_tick", int'(tick), 1);
        check("post_load_count", int'(count), 10);

        // 6: asynchronous reset between edges clears the outputs immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_dir", int'(dir_down), 0);
        cyc(2);
        rst_n = 1'b1;

        // Bound behaviour at MAX in up mode and at 0 in down mode.
        mode = 2'b01; load = 1'b1; load_value = 4'd15;
        cyc(1);
        load = 1'b0;
        cyc(4);
`ifdef COUNTER_SATURATE_EN
        check("bound_up_count", int'(count), 15);
`else
        check("bound_up_count", int'(count), 0);
`endif
        check("bound_up_tc", int'(tc), 1);
        cyc(4);
`ifdef COUNTER_SATURATE_EN
        check("bound_up_count2", int'(count), 15);
        check("bound_up_tc2", int'(tc), 1);
`else
        check("bound_up_count2", int'(count), 1);
        check("bound_up_tc2", int'(tc), 0);
`endif
        mode = 2'b10; load = 1'b1; load_value = 4'd0;
        cyc(1);
        load = 1'b0;
        cyc(4);
`ifdef COUNTER_SATURATE_EN
        check("bound_down_count", int'(count), 0);
`else
        check("bound_down_count", int'(count), 15);
`endif
        check("bound_down_tc", int'(tc), 1);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
